// File: rtl/exec_unit.sv
// ============================================================================
//  Module   : exec_unit
//  Purpose  : Execute stage with operand select, 4-function ALU, branch resolve
//             and stall-able result register. Define EXEC_DELAY_EN to add
//             simulation delays on the combinational paths.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module exec_unit #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] DATA1,
    input  logic [DATA_W-1:0] DATA2,
    input  logic [DATA_W-1:0] IMMEDIATE,
    input  logic [2:0]        SELECT_OP,
    input  logic              NEG_SEL,
    input  logic              IMM_SEL,
    input  logic [7:0]        OFFSET,
    input  logic              J,
    input  logic              BEQ,
    input  logic              BNE,
    input  logic              BUSY,
    output logic [DATA_W-1:0] ALU_RESULT,
    output logic              ZERO,
    output logic              TAKEN,
    output logic [PC_W-1:0]   BRANCH_OFFSET,
    output logic [DATA_W-1:0] RESULT_Q,
    output logic              ZERO_Q
);

    localparam logic [DATA_W-1:0] C_ONE = DATA_W'(1);

    logic [DATA_W-1:0] w_neg_val;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_fwd;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_and;
    logic [DATA_W-1:0] w_or;
    logic [DATA_W-1:0] w_alu;
    logic [PC_W-1:0]   w_byte_off;

    // Word offset to byte offset: sign-extend then scale by 4.
    assign w_byte_off = {{(PC_W-10){OFFSET[7]}}, OFFSET, 2'b00};

    // NEG_SEL only matters on the register path; immediates are never negated.
    assign w_op_b = !IMM_SEL ? IMMEDIATE : (NEG_SEL ? w_neg_val : DATA2);

`ifdef EXEC_DELAY_EN
    assign #1 w_neg_val     = ~DATA2 + C_ONE;
    assign #1 w_fwd         = w_op_b;
    assign #2 w_sum         = DATA1 + w_op_b;
    assign #1 w_and         = DATA1 & w_op_b;
    assign #1 w_or          = DATA1 | w_op_b;
    assign #2 BRANCH_OFFSET = TAKEN ? w_byte_off : '0;
`else
    assign w_neg_val     = ~DATA2 + C_ONE;
    assign w_fwd         = w_op_b;
    assign w_sum         = DATA1 + w_op_b;
    assign w_and         = DATA1 & w_op_b;
    assign w_or          = DATA1 | w_op_b;
    assign BRANCH_OFFSET = TAKEN ? w_byte_off : '0;
`endif

    always_comb begin
        w_alu = '0;
        case (SELECT_OP)
            3'b000:  w_alu = w_fwd;
            3'b001:  w_alu = w_sum;
            3'b010:  w_alu = w_and;
            3'b011:  w_alu = w_or;
            default: w_alu = '0;
        endcase
    end

    assign ALU_RESULT = w_alu;
    assign ZERO       = (w_alu == '0);
    assign TAKEN      = J | (BEQ & ZERO) | (BNE & ~ZERO);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RESULT_Q <= '0;
            ZERO_Q   <= 1'b0;
        end else if (!BUSY) begin
            RESULT_Q <= w_alu;
            ZERO_Q   <= ZERO;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// ============================================================================
//  Module   : tb_exec_unit
//  Purpose  : Directed table-driven bench for exec_unit plus register/reset
//             sequences.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exec_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  DATA1, DATA2, IMMEDIATE, OFFSET;
    logic [2:0]  SELECT_OP;
    logic        NEG_SEL, IMM_SEL, J, BEQ, BNE, BUSY;
    logic [7:0]  ALU_RESULT, RESULT_Q;
    logic        ZERO, TAKEN, ZERO_Q;
    logic [31:0] BRANCH_OFFSET;

    int total = 0;
    int bad   = 0;

    exec_unit #(.DATA_W(8), .PC_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .DATA1(DATA1), .DATA2(DATA2),
        .IMMEDIATE(IMMEDIATE), .SELECT_OP(SELECT_OP), .NEG_SEL(NEG_SEL),
        .IMM_SEL(IMM_SEL), .OFFSET(OFFSET), .J(J), .BEQ(BEQ), .BNE(BNE),
        .BUSY(BUSY), .ALU_RESULT(ALU_RESULT), .ZERO(ZERO), .TAKEN(TAKEN),
        .BRANCH_OFFSET(BRANCH_OFFSET), .RESULT_Q(RESULT_Q), .ZERO_Q(ZERO_Q)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  d1, d2, imm, off;
        logic [2:0]  op;
        logic        neg, immsel, j, beq, bne;
        logic [7:0]  e_res;
        logic        e_zero, e_taken;
        logic [31:0] e_boff;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        DATA1 = v.d1; DATA2 = v.d2; IMMEDIATE = v.imm; OFFSET = v.off;
        SELECT_OP = v.op; NEG_SEL = v.neg; IMM_SEL = v.immsel;
        J = v.j; BEQ = v.beq; BNE = v.bne;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] d1, d2, imm, input logic [2:0] op,
                                input logic neg, immsel, input logic [7:0] off,
                                input logic j, beq, bne, input logic [7:0] e_res,
                                input logic e_zero, e_taken, input logic [31:0] e_boff);
        vec_t v;
        v.d1 = d1; v.d2 = d2; v.imm = imm; v.op = op; v.neg = neg; v.immsel = immsel;
        v.off = off; v.j = j; v.beq = beq; v.bne = bne;
        v.e_res = e_res; v.e_zero = e_zero; v.e_taken = e_taken; v.e_boff = e_boff;
        return v;
    endfunction

    initial begin
        //          d1     d2     imm    op     neg   isel off    j     beq   bne   res    z     tk    boff
        vecs[0]  = mk(8'h00, 8'h00, 8'h2A, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0, 32'h0);
        vecs[1]  = mk(8'h05, 8'h05, 8'h00, 3'd1, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 32'hFFFFFFF8);
        vecs[2]  = mk(8'h05, 8'h03, 8'h00, 3'd1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 32'h00000008);
        vecs[3]  = mk(8'h05, 8'h03, 8'h00, 3'd1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 32'h0);
        vecs[4]  = mk(8'hF0, 8'h3C, 8'h00, 3'd2, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 32'h0);
        vecs[5]  = mk(8'hF0, 8'h3C, 8'h00, 3'd3, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFC, 1'b0, 1'b0, 32'h0);
        vecs[6]  = mk(8'hFF, 8'h01, 8'h00, 3'd1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        vecs[7]  = mk(8'hF0, 8'h3C, 8'h00, 3'd6, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'hFFFFFFFC);
        vecs[8]  = mk(8'h00, 8'h80, 8'h00, 3'd0, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 32'h000001FC);
        vecs[9]  = mk(8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0);
        vecs[10] = mk(8'h00, 8'h01, 8'h00, 3'd0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 32'h00000004);
        vecs[11] = mk(8'h01, 8'h55, 8'h10, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 32'h0);
        vecs[12] = mk(8'hFF, 8'hFF, 8'hFF, 3'd4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        vecs[13] = mk(8'hFF, 8'hFF, 8'hFF, 3'd7, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        vecs[14] = mk(8'h00, 8'h01, 8'h00, 3'd3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 32'h0);

        RESET = 1'b0;
        BUSY  = 1'b0;
        drive(vecs[0]);

        // Registers stay cleared while reset is low, even across edges.
        tick();
        tick();
        check("reset_result_q", 32'(RESULT_Q), 32'h00);
        check("reset_zero_q", 32'(ZERO_Q), 32'h0);

        // Combinational table; unaffected by reset being low.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            #3;
            check($sformatf("v%0d_alu", i), 32'(ALU_RESULT), 32'(vecs[i].e_res));
            check($sformatf("v%0d_zero", i), 32'(ZERO), 32'(vecs[i].e_zero));
            check($sformatf("v%0d_taken", i), 32'(TAKEN), 32'(vecs[i].e_taken));
            check($sformatf("v%0d_boff", i), BRANCH_OFFSET, vecs[i].e_boff);
        end

        // Release reset and capture 0x2A.
        @(negedge CLK);
        RESET = 1'b1;
        drive(vecs[0]);
        tick();
        check("cap_result_q", 32'(RESULT_Q), 32'h2A);
        check("cap_zero_q", 32'(ZERO_Q), 32'h0);

        // Stall: inputs change to a zero result, registers must hold.
        @(negedge CLK);
        BUSY = 1'b1;
        drive(vecs[7]);
        tick();
        tick();
        check("busy_result_q", 32'(RESULT_Q), 32'h2A);
        check("busy_zero_q", 32'(ZERO_Q), 32'h0);

        // Asynchronous reset mid-cycle during the stall.
        #2;
        RESET = 1'b0;
        #1;
        check("async_rst_result_q", 32'(RESULT_Q), 32'h00);
        check("async_rst_zero_q", 32'(ZERO_Q), 32'h0);

        // Held through an edge with BUSY low.
        BUSY = 1'b0;
        drive(vecs[0]);
        tick();
        check("rst_hold_result_q", 32'(RESULT_Q), 32'h00);

        // Release during a stall: no capture until BUSY drops.
        @(negedge CLK);
        RESET = 1'b1;
        BUSY  = 1'b1;
        tick();
        check("rel_busy_result_q", 32'(RESULT_Q), 32'h00);
        check("rel_busy_zero_q", 32'(ZERO_Q), 32'h0);

        @(negedge CLK);
        BUSY = 1'b0;
        drive(vecs[1]);
        tick();
        check("first_cap_result_q", 32'(RESULT_Q), 32'h00);
        check("first_cap_zero_q", 32'(ZERO_Q), 32'h1);

        @(negedge CLK);
        drive(vecs[5]);
        tick();
        check("next_cap_result_q", 32'(RESULT_Q), 32'hFC);
        check("next_cap_zero_q", 32'(ZERO_Q), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, operand/result width; PC_W, 32, branch-offset width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- DATA1  in  DATA_W  register operand A (ALU first operand).
- DATA2  in  DATA_W  register operand B source.
- IMMEDIATE  in  DATA_W  instruction immediate.
- SELECT_OP  in  3  ALU function select.
- NEG_SEL  in  1  1 = use two's complement of DATA2.
- IMM_SEL  in  1  0 = operand B is IMMEDIATE; 1 = operand B is the DATA2 path.
- OFFSET  in  8  signed branch/jump offset in instruction words.
- J, BEQ, BNE  in  1 each  jump / branch-if-equal / branch-if-not-equal strobes.
- BUSY  in  1  stall; holds registered outputs.
- ALU_RESULT  out  DATA_W  combinational ALU result.
- ZERO  out  1  combinational, ALU_RESULT == 0.
- TAKEN  out  1  combinational, control transfer taken.
- BRANCH_OFFSET  out  PC_W  combinational byte offset for PC update.
- RESULT_Q  out  DATA_W  registered ALU_RESULT.
- ZERO_Q  out  1  registered ZERO.

Function
REQ-003 NEG_VAL SHALL be (~DATA2)+1 modulo 2^DATA_W; 0x00->0x00, 0x80->0x80, 0x01->0xFF.
REQ-004 Operand B SHALL be IMMEDIATE when IMM_SEL=0, else NEG_VAL when NEG_SEL=1, else DATA2; NEG_SEL is ignored when IMM_SEL=0.
REQ-005 SELECT_OP 000 SHALL give ALU_RESULT = B (forward).
REQ-006 SELECT_OP 001 SHALL give ALU_RESULT = (DATA1+B) mod 2^DATA_W, carry discarded; with NEG_SEL=1 this is subtraction.
REQ-007 SELECT_OP 010 SHALL give DATA1 & B; 011 SHALL give DATA1 | B.
REQ-008 SELECT_OP 100-111 SHALL give ALU_RESULT = 0, never X.
REQ-009 ZERO SHALL be 1 exactly when ALU_RESULT is all zeros, for every SELECT_OP.
REQ-010 TAKEN SHALL equal J | (BEQ & ZERO) | (BNE & ~ZERO); simultaneous strobes are ORed.
REQ-011 BRANCH_OFFSET SHALL equal sign-extend(OFFSET) shifted left 2 to PC_W bits when TAKEN=1, else 0.
- OFFSET 0xFF -> 0xFFFFFFFC; 0x7F -> 0x000001FC.
REQ-012 On each CLK rising edge with RESET high and BUSY=0, RESULT_Q<=ALU_RESULT and ZERO_Q<=ZERO; with BUSY=1 both SHALL hold.
REQ-013 Combinational outputs SHALL respond to inputs independently of CLK, BUSY and RESET.

Reset
REQ-014 RESET low SHALL immediately force RESULT_Q=0 and ZERO_Q=0, independent of CLK, and SHALL hold them while low.
REQ-015 When RESET rises, the first capture SHALL occur on the next CLK rising edge with BUSY=0; reset during a BUSY stall SHALL still clear the registers.

Configuration
REQ-016 With EXEC_DELAY_EN defined, combinational paths SHALL carry simulation delays (1 ns units):
- NEG_VAL: #1.
- ALU forward/AND/OR: #1.
- ALU add: #2.
- BRANCH_OFFSET: #2.
REQ-017 Without EXEC_DELAY_EN, all combinational paths SHALL be zero-delay; registered-output behaviour SHALL be identical in both builds.

Verification
REQ-018 IMM_SEL=0, IMMEDIATE=0x2A, SELECT_OP=000 -> ALU_RESULT=0x2A, ZERO=0.
REQ-019 DATA1=0x05, DATA2=0x05, IMM_SEL=1, NEG_SEL=1, SELECT_OP=001, BEQ=1, OFFSET=0xFE -> ALU_RESULT=0x00, ZERO=1, TAKEN=1, BRANCH_OFFSET=0xFFFFFFF8.
REQ-020 Same operands with DATA2=0x03 and BNE=1, BEQ=0, OFFSET=0x02 -> ALU_RESULT=0x02, TAKEN=1, BRANCH_OFFSET=0x00000008; with BEQ=1 instead -> TAKEN=0, BRANCH_OFFSET=0.
REQ-021 DATA1=0xF0, DATA2=0x3C, IMM_SEL=1: SELECT_OP=010 -> 0x30; SELECT_OP=011 -> 0xFC; SELECT_OP=001 with DATA1=0xFF, DATA2=0x01 -> 0x00, ZERO=1; SELECT_OP=110 -> 0x00.
REQ-022 Capture 0x2A, then assert BUSY=1 and change inputs -> RESULT_Q stays 0x2A; then pull RESET low mid-cycle -> RESULT_Q=0, ZERO_Q=0 immediately, before the next edge.
